imm_encode_loader: RTL and testbench

//  Inverse of the decode-side immediate extender: range-checks a 32-bit immediate,

---
 rtl/isa_pkg.sv | 19 +
 rtl/imm_encode_loader_if.sv | 28 ++
 rtl/imm_encode_loader_imm_compress.sv | 31 +++
 rtl/imm_encode_loader.sv | 105 ++++++++++
 tb/tb_imm_encode_loader.sv | 359 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/isa_pkg.sv
// rtl/isa_pkg.sv - shared instruction-format constants and immediate extension classes
package isa_pkg;

    localparam int IMM_W   = 20;
    localparam int FIELD_W = 12;
    localparam int INSTR_W = 32;

    typedef enum logic {
        EXT_ZERO = 1'b0,
        EXT_JUMP = 1'b1
    } ext_sel_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DRAIN = 2'd2
    } load_state_t;

endpackage

// File: rtl/imm_encode_loader_if.sv
// rtl/imm_encode_loader_if.sv - word source stream and instruction-memory write port
interface imm_encode_loader_if
    import isa_pkg::*;
#(
    parameter int ADDR_W = 10
) ();

    logic               in_valid;
    logic               in_ready;
    ext_sel_t           in_mode;
    logic [FIELD_W-1:0] in_fields;
    logic [INSTR_W-1:0] in_imm;

    logic               mem_we;
    logic [ADDR_W-1:0]  mem_addr;
    logic [INSTR_W-1:0] mem_wdata;

    modport master (
        output in_valid, in_mode, in_fields, in_imm,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_mode, in_fields, in_imm,
        output in_ready, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/imm_encode_loader_imm_compress.sv
// rtl/imm_encode_loader_imm_compress.sv - 32-bit immediate to 20-bit field with legality flag
module imm_compress
    import isa_pkg::*;
(
    input  ext_sel_t           mode,
    input  logic [INSTR_W-1:0] imm,
    output logic [IMM_W-1:0]   imm20,
    output logic               legal
);

    // Jump class is sign-extended from bit 19, so bits 31:19 must all agree.
    always_comb begin
        imm20 = '0;
        legal = 1'b0;
        case (mode)
            EXT_ZERO: begin
                imm20 = {4'b0000, imm[15:0]};
                legal = (imm[31:16] == 16'h0000);
            end
            EXT_JUMP: begin
                imm20 = imm[19:0];
                legal = (&imm[31:19]) | ~(|imm[31:19]);
            end
            default: begin
                imm20 = '0;
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/imm_encode_loader.sv
// rtl/imm_encode_loader.sv - encodes immediates and streams instruction words into memory
module imm_encode_loader
    import isa_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    imm_encode_loader_if.slave bus,
    output logic              busy,
    output logic              done,
    output logic              range_err,
    output logic [ADDR_W-1:0] err_addr
);

    load_state_t        state_q, state_d;
    logic [CNT_W-1:0]   remaining_q;
    logic [ADDR_W-1:0]  addr_q;
    logic               mem_we_q;
    logic [ADDR_W-1:0]  mem_addr_q;
    logic [INSTR_W-1:0] mem_wdata_q;
    logic               done_q;
    logic               range_err_q;
    logic [ADDR_W-1:0]  err_addr_q;

    logic [IMM_W-1:0]   imm20;
    logic               legal;
    logic               xfer;
    logic               last_xfer;
    logic               start_idle;

    imm_compress u_compress (
        .mode  (bus.in_mode),
        .imm   (bus.in_imm),
        .imm20 (imm20),
        .legal (legal)
    );

    assign bus.in_ready = (state_q == S_LOAD) && (remaining_q != '0);
    assign xfer         = bus.in_valid & bus.in_ready;
    assign last_xfer    = xfer && (remaining_q == CNT_W'(1));
    assign start_idle   = (state_q == S_IDLE) && start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start && (word_count != '0)) state_d = S_LOAD;
            S_LOAD:  if (last_xfer) state_d = S_DRAIN;
            S_DRAIN: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // done is registered so it lands in the DRAIN cycle, alongside the final write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remaining_q <= '0;
            addr_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            done_q      <= 1'b0;
            range_err_q <= 1'b0;
            err_addr_q  <= '0;
        end else begin
            mem_we_q <= xfer;
            done_q   <= ((state_q == S_LOAD) && last_xfer) ||
                        (start_idle && (word_count == '0));
            if (start_idle) begin
                addr_q      <= base_addr;
                remaining_q <= word_count;
                range_err_q <= 1'b0;
                err_addr_q  <= '0;
            end
            if (xfer) begin
                mem_addr_q  <= addr_q;
                mem_wdata_q <= {bus.in_fields, imm20};
                addr_q      <= addr_q + ADDR_W'(1);
                remaining_q <= remaining_q - CNT_W'(1);
                if (!legal && !range_err_q) begin
                    range_err_q <= 1'b1;
                    err_addr_q  <= addr_q;
                end
            end
        end
    end

    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign busy          = (state_q != S_IDLE);
    assign done          = done_q;
    assign range_err     = range_err_q;
    assign err_addr      = err_addr_q;

endmodule

// File: tb/tb_imm_encode_loader.sv
// tb/tb_imm_encode_loader.sv - directed self-checking bench for imm_encode_loader
module tb_imm_encode_loader;
    import isa_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [9:0]  base_addr;
    logic [10:0] word_count;
    logic        busy;
    logic        done;
    logic        range_err;
    logic [9:0]  err_addr;

    int total;
    int bad;
    int cyc;
    int done_cnt;

    logic [9:0]  wr_addr [$];
    logic [31:0] wr_data [$];
    int          wr_cyc  [$];
    logic        done_we [$];

    imm_encode_loader_if #(.ADDR_W(10)) bus ();

    imm_encode_loader #(.ADDR_W(10), .CNT_W(11)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .bus        (bus.slave),
        .busy       (busy),
        .done       (done),
        .range_err  (range_err),
        .err_addr   (err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.mem_we) begin
            wr_addr.push_back(bus.mem_addr);
            wr_data.push_back(bus.mem_wdata);
            wr_cyc.push_back(cyc);
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            done_we.push_back(bus.mem_we);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        done_we.delete();
        done_cnt = 0;
    endtask

    task automatic pulse_start(input logic [9:0] b, input logic [10:0] n);
        start      = 1'b1;
        base_addr  = b;
        word_count = n;
        tick();
        start      = 1'b0;
    endtask

    task automatic send_word(input ext_sel_t m, input logic [11:0] f, input logic [31:0] v);
        bus.in_valid  = 1'b1;
        bus.in_mode   = m;
        bus.in_fields = f;
        bus.in_imm    = v;
        for (int w = 0; w < 20 && !bus.in_ready; w++) tick();
        total++;
        if (!bus.in_ready) begin
            bad++;
            $display("FAIL send_timeout: in_ready=%0b want 1", bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++;
        if ({bus.mem_we, busy, done, range_err, bus.in_ready} !== 5'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b want 00000",
                     {bus.mem_we, busy, done, range_err, bus.in_ready});
        end
        total++;
        if (bus.mem_addr !== 10'h0 || err_addr !== 10'h0) begin
            bad++;
            $display("FAIL reset_addr: got %h/%h want 000/000", bus.mem_addr, err_addr);
        end
        total++;
        if (bus.mem_wdata !== 32'h0) begin
            bad++;
            $display("FAIL reset_wdata: got %h want 00000000", bus.mem_wdata);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_zero_ext();
        logic [9:0]  ea [3] = '{10'h010, 10'h011, 10'h012};
        logic [31:0] ed [3] = '{32'hABC01234, 32'hABC0FFFF, 32'hABC00000};
        logic [31:0] iv [3] = '{32'h0000_1234, 32'h0000_FFFF, 32'h0000_0000};
        clear_log();
        pulse_start(10'h010, 11'd3);
        for (int k = 0; k < 3; k++) send_word(EXT_ZERO, 12'hABC, iv[k]);
        repeat (3) tick();
        total++;
        if (wr_addr.size() != 3) begin
            bad++;
            $display("FAIL t1_nwrites: got %0d want 3", wr_addr.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                total++;
                if (wr_addr[k] !== ea[k] || wr_data[k] !== ed[k]) begin
                    bad++;
                    $display("FAIL t1_word%0d: got %h@%h want %h@%h",
                             k, wr_data[k], wr_addr[k], ed[k], ea[k]);
                end
            end
        end
        total++;
        if (done_cnt != 1 || done_we.size() != 1 || done_we[0] !== 1'b1) begin
            bad++;
            $display("FAIL t1_done: count=%0d with_last_write=%0b want 1/1",
                     done_cnt, (done_we.size() > 0) ? done_we[0] : 1'b0);
        end
        total++;
        if (range_err !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL t1_status: range_err=%0b busy=%0b want 0/0", range_err, busy);
        end
    endtask

    task automatic test_jump_ext();
        clear_log();
        pulse_start(10'h020, 11'd2);
        send_word(EXT_JUMP, 12'h123, 32'hFFFF_FFFE);
        send_word(EXT_JUMP, 12'h123, 32'h0007_FFFF);
        repeat (3) tick();
        total++;
        if (wr_data.size() != 2 || wr_data[0] !== 32'h123FFFFE || wr_data[1] !== 32'h1237FFFF) begin
            bad++;
            $display("FAIL t2_data: got n=%0d %h %h want 123ffffe 1237ffff", wr_data.size(),
                     (wr_data.size() > 0) ? wr_data[0] : 32'h0,
                     (wr_data.size() > 1) ? wr_data[1] : 32'h0);
        end
        total++;
        if (range_err !== 1'b0) begin
            bad++;
            $display("FAIL t2_range_err: got %0b want 0", range_err);
        end
    endtask

    task automatic test_range_err();
        clear_log();
        pulse_start(10'h005, 11'd2);
        send_word(EXT_ZERO, 12'h456, 32'h0001_0000);
        send_word(EXT_JUMP, 12'h456, 32'h0008_0000);
        repeat (3) tick();
        total++;
        if (wr_data.size() != 2 || wr_data[0] !== 32'h45600000 || wr_data[1] !== 32'h45680000) begin
            bad++;
            $display("FAIL t3_data: got n=%0d %h %h want 45600000 45680000", wr_data.size(),
                     (wr_data.size() > 0) ? wr_data[0] : 32'h0,
                     (wr_data.size() > 1) ? wr_data[1] : 32'h0);
        end
        total++;
        if (range_err !== 1'b1 || err_addr !== 10'h005) begin
            bad++;
            $display("FAIL t3_err: range_err=%0b err_addr=%h want 1/005", range_err, err_addr);
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] ea [4] = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
        clear_log();
        pulse_start(10'h3FE, 11'd4);
        total++;
        if (range_err !== 1'b0) begin
            bad++;
            $display("FAIL t4_err_clear: got %0b want 0", range_err);
        end
        bus.in_valid  = 1'b1;
        bus.in_mode   = EXT_ZERO;
        bus.in_fields = 12'h001;
        for (int k = 0; k < 4; k++) begin
            bus.in_imm = 32'(k);
            total++;
            if (bus.in_ready !== 1'b1) begin
                bad++;
                $display("FAIL t4_ready%0d: got %0b want 1", k, bus.in_ready);
            end
            tick();
        end
        total++;
        if (bus.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL t4_ready_after: got %0b want 0", bus.in_ready);
        end
        bus.in_valid = 1'b0;
        repeat (3) tick();
        total++;
        if (wr_addr.size() != 4) begin
            bad++;
            $display("FAIL t4_nwrites: got %0d want 4", wr_addr.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                total++;
                if (wr_addr[k] !== ea[k] || wr_data[k] !== (32'h00100000 | 32'(k))) begin
                    bad++;
                    $display("FAIL t4_word%0d: got %h@%h want %h@%h",
                             k, wr_data[k], wr_addr[k], 32'h00100000 | 32'(k), ea[k]);
                end
            end
            total++;
            if (wr_cyc[3] - wr_cyc[0] != 3) begin
                bad++;
                $display("FAIL t4_spacing: got %0d cycles want 3", wr_cyc[3] - wr_cyc[0]);
            end
        end
    endtask

    task automatic test_zero_count();
        clear_log();
        pulse_start(10'h100, 11'd0);
        total++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL t5_done_pulse: done=%0b busy=%0b want 1/0", done, busy);
        end
        tick();
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL t5_done_clear: got %0b want 0", done);
        end
        repeat (2) tick();
        total++;
        if (wr_addr.size() != 0) begin
            bad++;
            $display("FAIL t5_no_write: got %0d writes want 0", wr_addr.size());
        end
    endtask

    task automatic test_start_ignored();
        clear_log();
        pulse_start(10'h040, 11'd2);
        send_word(EXT_ZERO, 12'h777, 32'h0000_0011);
        pulse_start(10'h200, 11'd5);
        send_word(EXT_ZERO, 12'h777, 32'h0000_0022);
        repeat (3) tick();
        total++;
        if (wr_addr.size() != 2 || wr_addr[0] !== 10'h040 || wr_addr[1] !== 10'h041) begin
            bad++;
            $display("FAIL t5_ignore_addr: got n=%0d %h %h want 040 041", wr_addr.size(),
                     (wr_addr.size() > 0) ? wr_addr[0] : 10'h0,
                     (wr_addr.size() > 1) ? wr_addr[1] : 10'h0);
        end
        total++;
        if (done_cnt != 1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL t5_ignore_done: done_count=%0d busy=%0b want 1/0", done_cnt, busy);
        end
    endtask

    task automatic test_reset_mid_load();
        clear_log();
        pulse_start(10'h080, 11'd5);
        send_word(EXT_ZERO, 12'h999, 32'h0000_0001);
        send_word(EXT_ZERO, 12'h999, 32'h0000_0002);
        @(negedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.in_imm   = 32'h0000_0003;
        rst          = 1'b1;
        #1;
        total++;
        if ({bus.mem_we, busy, done, bus.in_ready} !== 4'b0 || bus.mem_wdata !== 32'h0) begin
            bad++;
            $display("FAIL t6_async_clear: flags=%b wdata=%h want 0000/00000000",
                     {bus.mem_we, busy, done, bus.in_ready}, bus.mem_wdata);
        end
        tick();
        tick();
        bus.in_valid = 1'b0;
        rst          = 1'b0;
        tick();
        total++;
        if (wr_addr.size() != 2) begin
            bad++;
            $display("FAIL t6_nwrites: got %0d want 2", wr_addr.size());
        end
        pulse_start(10'h0C0, 11'd1);
        send_word(EXT_JUMP, 12'h321, 32'hFFFF_FFFF);
        repeat (3) tick();
        total++;
        if (wr_addr.size() != 3 || wr_addr[2] !== 10'h0C0 || wr_data[2] !== 32'h321FFFFF) begin
            bad++;
            $display("FAIL t6_restart: got n=%0d %h@%h want 321fffff@0c0", wr_addr.size(),
                     (wr_data.size() > 2) ? wr_data[2] : 32'h0,
                     (wr_addr.size() > 2) ? wr_addr[2] : 10'h0);
        end
        total++;
        if (done_cnt != 1) begin
            bad++;
            $display("FAIL t6_done: got %0d want 1", done_cnt);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        total         = 0;
        bad           = 0;
        cyc           = 0;
        done_cnt      = 0;
        rst           = 1'b1;
        start         = 1'b0;
        base_addr     = '0;
        word_count    = '0;
        bus.in_valid  = 1'b0;
        bus.in_mode   = EXT_ZERO;
        bus.in_fields = '0;
        bus.in_imm    = '0;
        test_reset();
        test_zero_ext();
        test_jump_ext();
        test_range_err();
        test_back_to_back();
        test_zero_count();
        test_start_ignored();
        test_reset_mid_load();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
